sha3_hash_ctrl: RTL

- Sequencer for the keccak datapath.
- On a start request it clears the core, then streams CHUNK_COUNT message chunks from a synchronous-read ROM, holding each chunk for S cycles.
- It then serialises the D-bit digest as lowercase ASCII hex, MSB nibble first, into a uart_tx-style transmitter.
- Sits between the message ROM, the keccak instance and uart_tx in FPGA test tops; it replaces ad-hoc counter logic in the top.

---
 rtl/sha3_hash_ctrl.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sha3_hash_ctrl.sv
// sha3_hash_ctrl: sequencer between a message ROM, a keccak core and uart_tx.
// It clears the core, streams CHUNK_COUNT ROM words (S cycles each), then
// sends the D-bit digest as lowercase ASCII hex, MSB nibble first.
// Optional build macro: SHA3_CTRL_CRLF_EN appends CR, LF after the digest.
// All outputs are flops whose next value is decoded from the next state, so
// they line up with the state they describe and have no combinational paths.
module sha3_hash_ctrl #(
  parameter int D           = 512,
  parameter int S           = 4,
  parameter int CHUNK_COUNT = 29,
  parameter int AW          = (CHUNK_COUNT > 1) ? $clog2(CHUNK_COUNT) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] chunk_addr,
  output logic          hash_reset,
  output logic          hash_enable,
  input  logic [D-1:0]  digest,
  output logic [7:0]    tx_data,
  output logic          tx_data_ready,
  input  logic          tx_busy
);

  localparam int CW    = (S > 1) ? $clog2(S) : 1;
  localparam int NCHAR = D / 4;
  localparam int NW    = (NCHAR > 1) ? $clog2(NCHAR) : 1;

  localparam logic [CW-1:0] LAST_CYC   = CW'(S - 1);
  localparam logic [AW-1:0] LAST_CHUNK = AW'(CHUNK_COUNT - 1);
  localparam logic [NW-1:0] LAST_NIB   = NW'(NCHAR - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_PRIME   = 3'd2,
    ST_ABSORB  = 3'd3,
    ST_EMIT    = 3'd4,
    ST_WAIT_HI = 3'd5,
    ST_WAIT_LO = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  // Map a 4-bit value to its lowercase ASCII hex character.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] r;
    if (n < 4'd10) begin
      r = 8'h30 + {4'h0, n};
    end else begin
      r = 8'h57 + {4'h0, n};
    end
    return r;
  endfunction

  // Select nibble idx of the digest counting from the MSB end.
  function automatic logic [3:0] digest_nibble(input logic [D-1:0] dg,
                                               input logic [NW-1:0] idx);
    int         sh;
    logic [D-1:0] shifted;
    sh      = (NCHAR - 1 - int'(idx)) * 4;
    shifted = dg >> sh;
    return shifted[3:0];
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [AW-1:0]   chunk_q, chunk_d;
  logic [NW-1:0]   nib_q, nib_d;
  logic            trail_q, trail_d;         // sending the CR/LF trailer
  logic            trail_idx_q, trail_idx_d; // 0: CR, 1: LF
  logic            start_prev_q, start_prev_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            hash_reset_q, hash_reset_d;
  logic            hash_enable_q, hash_enable_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_data_ready_q, tx_data_ready_d;

  // Next-state and counter logic of the sequencer.
  always_comb begin
    state_d         = state_q;
    cyc_d           = cyc_q;
    chunk_d         = chunk_q;
    nib_d           = nib_q;
    trail_d         = trail_q;
    trail_idx_d     = trail_idx_q;
    tx_data_ready_d = 1'b0;
    start_prev_d    = start;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_CLEAR;
          cyc_d       = '0;
          chunk_d     = '0;
          nib_d       = '0;
          trail_d     = 1'b0;
          trail_idx_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_d = ST_PRIME;
        chunk_d = '0;
      end
      ST_PRIME: begin
        // One idle cycle so the ROM word for address 0 is valid in ABSORB.
        state_d = ST_ABSORB;
        cyc_d   = '0;
        chunk_d = '0;
      end
      ST_ABSORB: begin
        if (cyc_q == LAST_CYC) begin
          cyc_d = '0;
          if (chunk_q == LAST_CHUNK) begin
            // Address stays on the last chunk rather than wrapping.
            state_d = ST_EMIT;
            nib_d   = '0;
          end else begin
            chunk_d = chunk_q + AW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      ST_EMIT: begin
        if (!tx_busy) begin
          tx_data_ready_d = 1'b1;
          state_d         = ST_WAIT_HI;
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_WAIT_HI: begin
        if (tx_busy) begin
          state_d = ST_WAIT_LO;
        end else begin
          state_d = ST_WAIT_HI;
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          if (trail_q) begin
            if (trail_idx_q) begin
              state_d = ST_DONE;
            end else begin
              trail_idx_d = 1'b1;
              state_d     = ST_EMIT;
            end
          end else if (nib_q == LAST_NIB) begin
`ifdef SHA3_CTRL_CRLF_EN
            trail_d     = 1'b1;
            trail_idx_d = 1'b0;
            state_d     = ST_EMIT;
`else
            state_d = ST_DONE;
`endif
          end else begin
            nib_d   = nib_q + NW'(1);
            state_d = ST_EMIT;
          end
        end else begin
          state_d = ST_WAIT_LO;
        end
      end
      ST_DONE: begin
        // Only a fresh rising edge restarts; a start level held over from
        // the previous run is ignored.
        if (start && !start_prev_q) begin
          state_d     = ST_CLEAR;
          cyc_d       = '0;
          chunk_d     = '0;
          nib_d       = '0;
          trail_d     = 1'b0;
          trail_idx_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so registered outputs track the state.
  always_comb begin
    busy_d        = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d        = (state_d == ST_DONE);
    hash_reset_d  = (state_d == ST_CLEAR);
    hash_enable_d = (state_d == ST_ABSORB);
    tx_data_d     = tx_data_q;
    if (state_d == ST_EMIT) begin
      if (trail_d) begin
        tx_data_d = trail_idx_d ? 8'h0A : 8'h0D;
      end else begin
        tx_data_d = hex_ascii(digest_nibble(digest, nib_d));
      end
    end else begin
      tx_data_d = tx_data_q;
    end
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      cyc_q           <= '0;
      chunk_q         <= '0;
      nib_q           <= '0;
      trail_q         <= 1'b0;
      trail_idx_q     <= 1'b0;
      start_prev_q    <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      hash_reset_q    <= 1'b0;
      hash_enable_q   <= 1'b0;
      tx_data_q       <= 8'h00;
      tx_data_ready_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cyc_q           <= cyc_d;
      chunk_q         <= chunk_d;
      nib_q           <= nib_d;
      trail_q         <= trail_d;
      trail_idx_q     <= trail_idx_d;
      start_prev_q    <= start_prev_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      hash_reset_q    <= hash_reset_d;
      hash_enable_q   <= hash_enable_d;
      tx_data_q       <= tx_data_d;
      tx_data_ready_q <= tx_data_ready_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign chunk_addr    = chunk_q;
  assign hash_reset    = hash_reset_q;
  assign hash_enable   = hash_enable_q;
  assign tx_data       = tx_data_q;
  assign tx_data_ready = tx_data_ready_q;

endmodule
